// File: rtl/musicbox_input_conditioner_pkg.sv
// Shared channel map and constants for the music box input conditioner.
package musicbox_input_pkg;

  localparam int NUM_BUTTONS  = 4;
  localparam int NUM_KEYS     = 6;
  localparam int NUM_CHANNELS = 10;

  localparam int CH_PLAYSONG0     = 0;
  localparam int CH_PLAYSONG1     = 1;
  localparam int CH_MAKERECORDING = 2;
  localparam int CH_PLAYRECORDING = 3;
  localparam int CH_KEY0          = 4;

  localparam int DEFAULT_DEBOUNCE_MS = 20;

  typedef logic [NUM_CHANNELS-1:0] chan_vec_t;

  // Adds k to a 16-bit count and pins the result at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] a, input logic [3:0] k);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'b0, k};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/musicbox_input_conditioner_if.sv
// Raw GPIO in / conditioned levels and pulses out; master drives raw inputs, slave is the conditioner.
interface musicbox_input_conditioner_if;
  import musicbox_input_pkg::*;

  logic                   clock_1Khz;
  logic [NUM_BUTTONS-1:0] raw_buttons_n;
  logic [NUM_KEYS-1:0]    raw_music_key_n;
  logic [NUM_BUTTONS-1:0] stable_buttons_n;
  logic [NUM_KEYS-1:0]    stable_music_key_n;
  chan_vec_t              press_pulse;
  chan_vec_t              release_pulse;
  logic [15:0]            glitch_count;

  modport master (
    output clock_1Khz, raw_buttons_n, raw_music_key_n,
    input  stable_buttons_n, stable_music_key_n, press_pulse, release_pulse, glitch_count
  );

  modport slave (
    input  clock_1Khz, raw_buttons_n, raw_music_key_n,
    output stable_buttons_n, stable_music_key_n, press_pulse, release_pulse, glitch_count
  );

endinterface

// File: rtl/musicbox_debounce_channel.sv
// One active-low input channel: synchroniser, tick-based debounce counter, registered edge pulses.
// Release-pulse flop exists only when MUSICBOX_INPUT_RELEASE_PULSE_EN is defined.
module musicbox_debounce_channel
  import musicbox_input_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_raw_n,
  output logic o_stable_n,
  output logic o_press,
  output logic o_release,
  output logic o_abort
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_MS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_q;
  logic [CW-1:0]          r_cnt;
  logic                   r_press;
  logic                   w_s;
  logic                   w_accept;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_accept = (w_s != r_q) && i_tick && (r_cnt == C_LAST);
  // A half-counted change that falls back to the accepted level is a rejected glitch.
  assign o_abort  = (w_s == r_q) && (r_cnt != '0);

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_q     <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw_n};
      r_press <= w_accept & ~w_s;
      if (w_s == r_q) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == C_LAST) begin
          r_q   <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

`ifdef MUSICBOX_INPUT_RELEASE_PULSE_EN
  logic r_release;

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_release <= 1'b0;
    end else begin
      r_release <= w_accept & w_s;
    end
  end

  assign o_release = r_release;
`else
  assign o_release = 1'b0;
`endif

  assign o_stable_n = r_q;
  assign o_press    = r_press;

endmodule

// File: rtl/musicbox_input_conditioner.sv
// Debounces 4 control buttons and 6 music keys; owns the 1 kHz tick and the glitch counter.
// Optional release pulses: define MUSICBOX_INPUT_RELEASE_PULSE_EN.
module musicbox_input_conditioner
  import musicbox_input_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clock_50Mhz,
  input  logic                         reset_n,
  musicbox_input_conditioner_if.slave  bus
);

  logic [1:0]  r_clk1k_sync;
  logic        r_clk1k_prev;
  logic [15:0] r_glitch_count;
  logic        w_tick;
  chan_vec_t   w_raw;
  chan_vec_t   w_stable;
  chan_vec_t   w_press;
  chan_vec_t   w_release;
  chan_vec_t   w_abort;
  logic [3:0]  w_abort_cnt;

  // clock_1Khz is data only: synchronise it and take one cycle per rising edge.
  assign w_tick = r_clk1k_sync[1] & ~r_clk1k_prev;
  assign w_raw  = {bus.raw_music_key_n, bus.raw_buttons_n};

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_clk1k_sync <= '0;
      r_clk1k_prev <= 1'b0;
    end else begin
      r_clk1k_sync <= {r_clk1k_sync[0], bus.clock_1Khz};
      r_clk1k_prev <= r_clk1k_sync[1];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    musicbox_debounce_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clock_50Mhz (clock_50Mhz),
      .reset_n     (reset_n),
      .i_tick      (w_tick),
      .i_raw_n     (w_raw[g]),
      .o_stable_n  (w_stable[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g]),
      .o_abort     (w_abort[g])
    );
  end

  always_comb begin
    w_abort_cnt = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_abort_cnt = w_abort_cnt + {3'b0, w_abort[i]};
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_count <= '0;
    end else begin
      r_glitch_count <= sat_inc16(r_glitch_count, w_abort_cnt);
    end
  end

  assign bus.stable_buttons_n   = w_stable[NUM_BUTTONS-1:0];
  assign bus.stable_music_key_n = w_stable[CH_KEY0 +: NUM_KEYS];
  assign bus.press_pulse        = w_press;
  assign bus.release_pulse      = w_release;
  assign bus.glitch_count       = r_glitch_count;

endmodule

// File: tb/tb_musicbox_input_conditioner.sv
// Directed bench for musicbox_input_conditioner with DEBOUNCE_MS=4 and a 100-cycle clock_1Khz.
module tb_musicbox_input_conditioner;
  import musicbox_input_pkg::*;

`ifdef MUSICBOX_INPUT_RELEASE_PULSE_EN
  localparam int REL_EXP = 1;
`else
  localparam int REL_EXP = 0;
`endif

  logic       clock_50Mhz = 1'b0;
  logic       reset_n     = 1'b0;
  logic       clk1k       = 1'b0;
  logic [3:0] raw_btn     = 4'hF;
  logic [5:0] raw_key     = 6'h3F;

  musicbox_input_conditioner_if bus();

  assign bus.clock_1Khz      = clk1k;
  assign bus.raw_buttons_n   = raw_btn;
  assign bus.raw_music_key_n = raw_key;

  musicbox_input_conditioner #(.DEBOUNCE_MS(4), .SYNC_STAGES(2)) dut (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #10 clock_50Mhz = ~clock_50Mhz;
  always #1000 clk1k = ~clk1k;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse monitor: counts pulses per channel and flags pulses not aligned with a stable edge.
  int        press_cnt[NUM_CHANNELS] = '{default: 0};
  int        rel_cnt[NUM_CHANNELS]   = '{default: 0};
  int        nz_cycles  = 0;
  int        misalign   = 0;
  logic [9:0] last_nz   = '0;
  logic [9:0] prev_stable = '1;

  always @(negedge clock_50Mhz) begin
    logic [9:0] st;
    st = {bus.stable_music_key_n, bus.stable_buttons_n};
    if (reset_n) begin
      if (bus.press_pulse != '0) begin
        nz_cycles++;
        last_nz = bus.press_pulse;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (bus.press_pulse[i]) begin
          press_cnt[i]++;
          if (st[i] || !prev_stable[i]) misalign++;
        end
        if (bus.release_pulse[i]) rel_cnt[i]++;
      end
    end
    prev_stable = st;
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk1k);
    repeat (10) @(negedge clock_50Mhz);
  endtask

  int base, base2, total;

  initial begin
    repeat (5) @(negedge clock_50Mhz);
    reset_n = 1'b1;
    repeat (2) @(negedge clock_50Mhz);

    chk("rst_buttons", 32'(bus.stable_buttons_n), 32'hF);
    chk("rst_keys",    32'(bus.stable_music_key_n), 32'h3F);
    chk("rst_press",   32'(bus.press_pulse), 32'h0);
    chk("rst_release", 32'(bus.release_pulse), 32'h0);
    chk("rst_glitch",  32'(bus.glitch_count), 32'h0);

    // Clean press of PlaySong0
    wait_ticks(1);
    base  = press_cnt[0];
    base2 = nz_cycles;
    raw_btn[0] = 1'b0;
    wait_ticks(3);
    chk("btn0_tick3",  32'(bus.stable_buttons_n), 32'hF);
    wait_ticks(1);
    chk("btn0_tick4",  32'(bus.stable_buttons_n), 32'hE);
    chk("btn0_keys",   32'(bus.stable_music_key_n), 32'h3F);
    chk("btn0_pulse",  32'(press_cnt[0] - base), 32'd1);
    wait_ticks(6);
    chk("btn0_held",   32'(bus.stable_buttons_n), 32'hE);
    chk("btn0_pcyc",   32'(nz_cycles - base2), 32'd1);
    base = rel_cnt[0];
    raw_btn[0] = 1'b1;
    wait_ticks(4);
    chk("btn0_rel",    32'(bus.stable_buttons_n), 32'hF);
    chk("btn0_relp",   32'(rel_cnt[0] - base), 32'(REL_EXP));

    // Key 2 bounce shorter than the debounce window
    raw_key[2] = 1'b0;
    wait_ticks(2);
    raw_key[2] = 1'b1;
    repeat (10) @(negedge clock_50Mhz);
    chk("glitch_cnt",  32'(bus.glitch_count), 32'd1);
    chk("glitch_keys", 32'(bus.stable_music_key_n), 32'h3F);
    chk("glitch_nop",  32'(press_cnt[CH_KEY0 + 2]), 32'd0);
    wait_ticks(4);
    chk("glitch_keep", 32'(bus.glitch_count), 32'd1);
    chk("glitch_keys2", 32'(bus.stable_music_key_n), 32'h3F);

    // PlaySong1 and PlayRecording together
    base2 = nz_cycles;
    raw_btn = 4'b0101;
    wait_ticks(4);
    chk("dual_stable", 32'(bus.stable_buttons_n), 32'h5);
    chk("dual_vec",    32'(last_nz), 32'h00A);
    chk("dual_pcyc",   32'(nz_cycles - base2), 32'd1);
    raw_btn = 4'hF;
    wait_ticks(4);
    chk("dual_rel",    32'(bus.stable_buttons_n), 32'hF);

    // Reset while MakeRecording is three ticks into its debounce
    raw_btn[2] = 1'b0;
    wait_ticks(3);
    chk("mr_pre",      32'(bus.stable_buttons_n), 32'hF);
    reset_n = 1'b0;
    repeat (3) @(negedge clock_50Mhz);
    chk("mr_rst_btn",  32'(bus.stable_buttons_n), 32'hF);
    chk("mr_rst_gl",   32'(bus.glitch_count), 32'h0);
    chk("mr_rst_pp",   32'(bus.press_pulse), 32'h0);
    @(negedge clk1k);
    repeat (5) @(negedge clock_50Mhz);
    base = press_cnt[CH_MAKERECORDING];
    reset_n = 1'b1;
    wait_ticks(3);
    chk("mr_tick3",    32'(bus.stable_buttons_n), 32'hF);
    wait_ticks(1);
    chk("mr_tick4",    32'(bus.stable_buttons_n), 32'hB);
    chk("mr_pulse",    32'(press_cnt[CH_MAKERECORDING] - base), 32'd1);
    raw_btn = 4'hF;
    wait_ticks(4);

    // Key 5 press then release
    base = press_cnt[CH_KEY0 + 5];
    raw_key[5] = 1'b0;
    wait_ticks(4);
    chk("k5_press",    32'(bus.stable_music_key_n), 32'h1F);
    chk("k5_pulse",    32'(press_cnt[CH_KEY0 + 5] - base), 32'd1);
    base = rel_cnt[CH_KEY0 + 5];
    raw_key[5] = 1'b1;
    wait_ticks(3);
    chk("k5_rtick3",   32'(bus.stable_music_key_n), 32'h1F);
    chk("k5_rel3",     32'(rel_cnt[CH_KEY0 + 5] - base), 32'd0);
    wait_ticks(1);
    chk("k5_rtick4",   32'(bus.stable_music_key_n), 32'h3F);
    chk("k5_relp",     32'(rel_cnt[CH_KEY0 + 5] - base), 32'(REL_EXP));

    total = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) total += rel_cnt[i];
    chk("rel_total",   32'(total), 32'(5 * REL_EXP));
    chk("align",       32'(misalign), 32'd0);
    chk("end_glitch",  32'(bus.glitch_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/musicbox_input_conditioner.md
Name: musicbox_input_conditioner

Overview:
- Conditions raw active-low GPIO inputs (4 control buttons, 6 music keys) before they reach the music box state controller.
- Per channel: synchronises to clock_50Mhz, debounces in 1 kHz ticks, and emits stable active-low levels plus one-cycle press pulses.
- Sits directly upstream of the state controller. Its stable outputs drive input_PlaySong0_n, input_PlaySong1_n, input_MakeRecording_n, input_PlayRecording_n and input_MusicKey.

Parameters:
- DEBOUNCE_MS, 20: consecutive 1 kHz ticks a changed level must persist before it is accepted. Legal range 1..255.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser. Legal range 2..4.

Ports:
- clock_50Mhz  input  1  sole clock.
- reset_n  input  1  reset, asynchronous, active-low.
- clock_1Khz  input  1  1 kHz square wave from the clock generator. Sampled as data only, never used as a clock.
- raw_buttons_n  input  4  raw control buttons, active-low: [0] PlaySong0, [1] PlaySong1, [2] MakeRecording, [3] PlayRecording.
- raw_music_key_n  input  6  raw music keys, active-low.
- stable_buttons_n  output  4  debounced control buttons, same bit order as raw_buttons_n.
- stable_music_key_n  output  6  debounced music keys.
- press_pulse  output  10  one-cycle pulse on a debounced 1->0 transition. [3:0] buttons, [9:4] keys.
- release_pulse  output  10  one-cycle pulse on a debounced 0->1 transition. Present only with the optional feature; tied to 0 otherwise.
- glitch_count  output  16  saturating count of rejected (aborted) level changes, summed over all channels.

Behaviour:
- Reset values:
  - Synchroniser flops: 1 (released).
  - stable_*: all 1.
  - press_pulse, release_pulse: 0.
  - glitch_count: 0.
  - Debounce counters: 0.
  - 1 kHz sampler flops: 0.
- Tick generation:
  - clock_1Khz passes through a 2-flop synchroniser, then a rising-edge detector.
  - tick is high for exactly one clock_50Mhz cycle per 1 kHz period.
- Per channel, with synced value s, accepted value q and counter c (width $clog2(DEBOUNCE_MS+1)):
  - If s == q: c <= 0. This happens every cycle, not only on tick.
  - If s != q and tick: if c == DEBOUNCE_MS-1, then q <= s and c <= 0; otherwise c <= c+1.
  - If s != q and no tick: c holds.
  - c never exceeds DEBOUNCE_MS-1; no wrap is possible.
- Latency: an input change is accepted on the clock_50Mhz cycle of the DEBOUNCE_MS-th tick after the change reaches s. That reaches s SYNC_STAGES cycles after the raw input changes.
- press_pulse[i] is asserted in the cycle after q falls from 1 to 0, for exactly one cycle. It is registered, so it is aligned with the cycle in which stable_* shows 0.
- Abort (glitch): the cycle in which s returns to q while c != 0. glitch_count increments by 1 per aborting channel. Simultaneous aborts on k channels add k. The count saturates at 16'hFFFF.
- Channels are fully independent. Simultaneous acceptance on several channels is legal, and all their pulses assert in the same cycle.
- Reset asserted mid-bounce: all state returns to reset values immediately.
- A button held through reset release is accepted as a press DEBOUNCE_MS ticks later and produces a normal press_pulse.
- clock_1Khz stuck high or low: no ticks occur, accepted values freeze, and counters hold.

Optional Feature:
- Macro MUSICBOX_INPUT_RELEASE_PULSE_EN.
- Defined: release_pulse[i] is asserted for one cycle after q rises from 0 to 1, with the same timing rule as press_pulse.
- Undefined: release_pulse is driven to constant 0 and no release-detect flops are built. All other behaviour is identical.

Decomposition:
- Package musicbox_input_pkg holds:
  - NUM_BUTTONS=4, NUM_KEYS=6, NUM_CHANNELS=10.
  - Channel index constants CH_PLAYSONG0=0, CH_PLAYSONG1=1, CH_MAKERECORDING=2, CH_PLAYRECORDING=3, CH_KEY0=4.
  - DEFAULT_DEBOUNCE_MS=20.
- Sub-module musicbox_debounce_channel implements one channel: synchroniser, counter, accepted value, pulse regs and abort flag. It is instantiated NUM_CHANNELS times via generate.
- The top level owns tick generation and glitch_count summation.

Test Plan:
- Bench setup for all scenarios: DEBOUNCE_MS=4, clock_1Khz period of 100 clock_50Mhz cycles.
- Reset -> stable_buttons_n=4'b1111, stable_music_key_n=6'b111111, press_pulse=0, glitch_count=0.
- Clean press of raw_buttons_n[0] held for 10 ticks -> stable_buttons_n[0]=0 at the 4th tick after sync; press_pulse[0] high exactly 1 cycle; no other bit changes.
- raw_music_key_n[2] low for 2 ticks, then high -> stable_music_key_n unchanged, no pulse, glitch_count=1.
- Buttons 1 and 3 pressed in the same cycle and held -> both stable bits fall in the same cycle; press_pulse=10'b0000001010 for one cycle.
- reset_n pulsed low while a press has c=3 -> all outputs return to reset values; with the input still held, the press is reaccepted 4 ticks after reset release with a single press_pulse.
- With MUSICBOX_INPUT_RELEASE_PULSE_EN defined, press then release key 5 -> release_pulse[9] high for one cycle 4 ticks after release. Without the macro, release_pulse stays 0 throughout.
